mem_stage: RTL
==============

Name: mem_stage

Overview:
- MEM pipeline stage of the five-stage MIPS core. Sits between EXE and WB.
- Latches the EXE result bus and waits for the data-SRAM response of loads and stores that were issued in EXE.
- Aligns load data, including sign/zero extension and LWL/LWR merge, and produces the MEM→WB bus with per-byte register-file write strobes.
- Drives a forward/block bus to ID.

Parameters:
- ES_TO_MS_BUS_WD, 106, EXE→MEM bus width.
- MS_TO_WS_BUS_WD, 74, MEM→WB bus width.
- MS_TO_DS_BUS_WD, 39, MEM→ID forward bus width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- ws_allowin  in  1  WB can accept this cycle
- ms_allowin  out  1  MEM can accept this cycle
- es_to_ms_valid  in  1  EXE offers an instruction
- es_to_ms_bus  in  106  {mem_req[105], ld_type[104:102], gr_we[101], dest[100:96], rt_value[95:64], alu_result[63:32], pc[31:0]}
- ms_to_ws_valid  out  1  MEM offers an instruction to WB
- ms_to_ws_bus  out  74  {rf_we[73:70], gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
- ms_to_ds_bus  out  39  {fwd_valid[38], fwd_blk[37], dest[36:32], result[31:0]}
- data_sram_data_ok  in  1  response for the oldest outstanding request
- data_sram_rdata  in  32  load data, valid with data_ok

Behaviour:
- Reset (resetn=0 at a clk edge): ms_valid=0, state=EMPTY, ms_to_ws_valid=0, ms_to_ds_bus fwd_valid=0. The bus register holds its value but every consumer is gated by ms_valid. Reset mid-WAIT drops the instruction; the SRAM side is reset in the same cycle, so no stale data_ok follows.
- ld_type encoding: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR. The mem_req bit marks a load or store that issued a request in EXE. Byte offset is a = alu_result[1:0].
- State machine:
  - EMPTY → (es_to_ms_valid & ms_allowin): WAIT if mem_req, else READY.
  - WAIT: on data_ok, capture rdata into a data buffer and go to READY.
  - READY → (ws_allowin): EMPTY, or WAIT/READY again if a new instruction is accepted in the same cycle.
- ms_ready_go = (state==READY). data_ok arriving in WAIT makes ready_go true in the following cycle (1-cycle buffered; never combinational from data_ok).
- ms_allowin = !ms_valid | (ms_ready_go & ws_allowin). ms_to_ws_valid = ms_valid & ms_ready_go.
- The bus register loads only when es_to_ms_valid & ms_allowin.
- The data buffer holds its value while READY and WB stalls (ws_allowin=0). A data_ok in EMPTY or READY is a protocol error and is ignored.
- Load alignment uses buffered data d = {b3,b2,b1,b0}:
  - LB/LBU: byte b[a], sign-/zero-extended.
  - LH/LHU: half at a[1], sign-/zero-extended.
  - LW: d.
- LWL result and rf_we by a:
  - a=0: {b0, rt[23:0]}, rf_we 1000
  - a=1: {b1,b0, rt[15:0]}, rf_we 1100
  - a=2: {b2,b1,b0, rt[7:0]}, rf_we 1110
  - a=3: d, rf_we 1111
- LWR result and rf_we by a:
  - a=0: d, rf_we 1111
  - a=1: {rt[31:24], b3,b2,b1}, rf_we 0111
  - a=2: {rt[31:16], b3,b2}, rf_we 0011
  - a=3: {rt[31:8], b3}, rf_we 0001
- All other instructions: rf_we=1111, final_result = alu_result (loads use the aligned data).
- Forward bus:
  - fwd_valid = ms_valid & gr_we & (dest≠0).
  - fwd_blk = fwd_valid & (ld_type≠0) & (state==WAIT). ID must stall on a match.
  - result = final_result when not blocked.
- Stores (mem_req=1, ld_type=0) also wait for data_ok. final_result is alu_result; gr_we comes from the bus (0 for stores).

Test Plan:
- ALU op (mem_req=0, alu_result=0x1234_5678, dest=5, gr_we=1), ws_allowin=1 → ms_to_ws_valid 1 cycle after acceptance; bus has rf_we=1111, final_result=0x12345678; ms_to_ds fwd_valid=1, fwd_blk=0.
- LB at a=3, data_ok with rdata=0x80FF_0000 two cycles after entry → fwd_blk=1 during WAIT; result 0xFFFF_FF80 one cycle after data_ok. LBU with the same data → 0x0000_0080.
- LWL a=1, rt=0xAABB_CCDD, rdata=0x1122_3344 → final_result=0x3344_CCDD, rf_we=1100. LWR a=2, same operands → 0xAABB_1122, rf_we=0011.
- Load returns data_ok while ws_allowin=0 for 3 cycles; rdata then changes → ms_to_ws_bus stays stable with the buffered value; ms_allowin=0 until the handoff.
- Back-to-back: a store in READY hands off while the next LW is accepted in the same cycle → state moves straight to WAIT with no bubble.
- resetn=0 asserted while in WAIT → next cycle ms_to_ws_valid=0, ms_allowin=1, fwd_valid=0; a new instruction is accepted normally.

Source files
------------

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- MEM pipeline stage of the five-stage MIPS core (between EXE/WB)
//
// Latches the EXE result bus, waits for the data-SRAM response of loads and
// stores issued in EXE, aligns load data (sign/zero extension, LWL/LWR merge)
// and produces the MEM->WB bus with per-byte register-file write strobes.
// Also drives a forward/block bus back to ID.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   ws_allowin         WB can accept this cycle
//   ms_allowin         MEM can accept this cycle
//   es_to_ms_valid     EXE offers an instruction
//   es_to_ms_bus       {mem_req, ld_type[2:0], gr_we, dest[4:0], rt_value,
//                       alu_result, pc}
//   ms_to_ws_valid     MEM offers an instruction to WB
//   ms_to_ws_bus       {rf_we[3:0], gr_we, dest[4:0], final_result, pc}
//   ms_to_ds_bus       {fwd_valid, fwd_blk, dest[4:0], result}
//   data_sram_data_ok  response for the oldest outstanding request
//   data_sram_rdata    load data, valid with data_ok
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 106,
    parameter int MS_TO_WS_BUS_WD = 74,
    parameter int MS_TO_DS_BUS_WD = 39
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LBU  = 3'd2;
    localparam logic [2:0] LD_LH   = 3'd3;
    localparam logic [2:0] LD_LHU  = 3'd4;
    localparam logic [2:0] LD_LW   = 3'd5;
    localparam logic [2:0] LD_LWL  = 3'd6;
    localparam logic [2:0] LD_LWR  = 3'd7;

    state_t                     state;
    state_t                     state_next;
    logic [ES_TO_MS_BUS_WD-1:0] bus_r;
    logic [31:0]                data_buf;

    logic        ms_valid;
    logic        ms_ready_go;
    logic        accept;
    logic        capture;

    logic        mem_req;
    logic [2:0]  ld_type;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] rt_value;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [1:0]  addr_lo;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] final_result;
    logic [3:0]  rf_we;
    logic        fwd_valid;
    logic        fwd_blk;

    assign {mem_req, ld_type, gr_we, dest, rt_value, alu_result, pc} = bus_r;
    assign addr_lo = alu_result[1:0];

    // The stage holds an instruction exactly when it is not EMPTY.
    assign ms_valid    = (state != S_EMPTY);
    assign ms_ready_go = (state == S_READY);
    assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
    assign accept      = es_to_ms_valid && ms_allowin;
    // Only a response in WAIT belongs to us; data_ok elsewhere is ignored.
    assign capture     = (state == S_WAIT) && data_sram_data_ok;

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; reset is synchronous, tested inside the clocked block.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the bus register and data buffer carry no reset -- every consumer
    // is qualified by ms_valid / state, so their contents after reset are
    // irrelevant and resetting them would only add fan-out on resetn.
    always_ff @(posedge clk) begin
        if (accept) begin
            bus_r <= es_to_ms_bus;
        end
        if (capture) begin
            data_buf <= data_sram_rdata;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_EMPTY: begin
                if (accept) begin
                    state_next = es_to_ms_bus[105] ? S_WAIT : S_READY;
                end
            end
            S_WAIT: begin
                if (data_sram_data_ok) begin
                    state_next = S_READY;
                end
            end
            S_READY: begin
                if (ws_allowin) begin
                    if (accept) begin
                        state_next = es_to_ms_bus[105] ? S_WAIT : S_READY;
                    end else begin
                        state_next = S_EMPTY;
                    end
                end
            end
            default: state_next = S_EMPTY;
        endcase
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        byte_sel = data_buf[7:0];
        unique case (addr_lo)
            2'd0: byte_sel = data_buf[7:0];
            2'd1: byte_sel = data_buf[15:8];
            2'd2: byte_sel = data_buf[23:16];
            2'd3: byte_sel = data_buf[31:24];
            default: byte_sel = data_buf[7:0];
        endcase
        half_sel = addr_lo[1] ? data_buf[31:16] : data_buf[15:0];

        final_result = alu_result;
        rf_we        = 4'b1111;
        unique case (ld_type)
            LD_NONE: final_result = alu_result;
            LD_LB:   final_result = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  final_result = {24'd0, byte_sel};
            LD_LH:   final_result = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  final_result = {16'd0, half_sel};
            LD_LW:   final_result = data_buf;
            // LWL fills the upper bytes from memory, keeping rt's low bytes.
            LD_LWL: begin
                unique case (addr_lo)
                    2'd0: begin final_result = {data_buf[7:0],  rt_value[23:0]}; rf_we = 4'b1000; end
                    2'd1: begin final_result = {data_buf[15:0], rt_value[15:0]}; rf_we = 4'b1100; end
                    2'd2: begin final_result = {data_buf[23:0], rt_value[7:0]};  rf_we = 4'b1110; end
                    default: begin final_result = data_buf;                      rf_we = 4'b1111; end
                endcase
            end
            // LWR fills the lower bytes from memory, keeping rt's high bytes.
            LD_LWR: begin
                unique case (addr_lo)
                    2'd0: begin final_result = data_buf;                          rf_we = 4'b1111; end
                    2'd1: begin final_result = {rt_value[31:24], data_buf[31:8]};  rf_we = 4'b0111; end
                    2'd2: begin final_result = {rt_value[31:16], data_buf[31:16]}; rf_we = 4'b0011; end
                    default: begin final_result = {rt_value[31:8], data_buf[31:24]}; rf_we = 4'b0001; end
                endcase
            end
            default: final_result = alu_result;
        endcase
    end

    // A load still waiting for its data cannot forward; ID must stall on it.
    assign fwd_valid = ms_valid && gr_we && (dest != 5'd0);
    assign fwd_blk   = fwd_valid && (ld_type != LD_NONE) && (state == S_WAIT);

    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign ms_to_ws_bus   = {rf_we, gr_we, dest, final_result, pc};
    assign ms_to_ds_bus   = {fwd_valid, fwd_blk, dest, final_result};

endmodule
